// File: rtl/mips_muldiv_unit_if.sv
// Request/response bundle between the control unit and the iterative MUL/DIV unit.
// The master issues start/op/operands; the slave returns handshake status and HI/LO.
interface mips_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative signed/unsigned multiply (shift-add) and divide (restoring) with private HI/LO.
// One result bit per cycle; magnitudes are processed and the sign is fixed up in FINISH.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  mips_muldiv_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             r_state, w_next;
  logic               r_busy, r_done, r_dbz;
  logic [WIDTH-1:0]   r_hi, r_lo, r_m;
  logic [2*WIDTH-1:0] r_acc, w_acc_step, w_prod_fix;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div, r_neg_q, r_neg_r;
  logic               w_accept, w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_q_fix, w_r_fix;
  logic [WIDTH:0]     w_sum, w_diff;

  // Operand decode: only ops 0..3 launch a computation; even ops are the signed ones.
  always_comb begin
    w_accept = bus.start && (r_state == S_IDLE) && (bus.op[2] == 1'b0);
    w_signed = ~bus.op[0];
    w_a_neg  = w_signed & bus.operand_a[WIDTH-1];
    w_b_neg  = w_signed & bus.operand_b[WIDTH-1];
    w_abs_a  = w_a_neg ? (-bus.operand_a) : bus.operand_a;
    w_abs_b  = w_b_neg ? (-bus.operand_b) : bus.operand_b;
  end

  // One iteration step: multiply shifts right after a conditional add, divide shifts left
  // and keeps the trial subtraction only when it does not borrow.
  always_comb begin
    w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
    w_diff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_m};
    if (r_is_div) begin
      if (w_diff[WIDTH]) begin
        w_acc_step = {r_acc[2*WIDTH-2:0], 1'b0};
      end else begin
        w_acc_step = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      w_acc_step = {w_sum, r_acc[WIDTH-1:1]};
    end
  end

  // Sign fix-up: remainder follows the dividend, quotient/product follow sign(a)^sign(b).
  always_comb begin
    w_prod_fix = r_neg_q ? (-r_acc) : r_acc;
    w_q_fix    = r_neg_q ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    w_r_fix    = r_neg_r ? (-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_CALC;
        else          w_next = S_IDLE;
      end
      S_CALC: begin
        if (r_cnt == CNT_ONE) w_next = S_FINISH;
        else                  w_next = S_CALC;
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Datapath, HI/LO and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
      r_m      <= {WIDTH{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                // Divide keeps the divisor in r_m; multiply keeps the multiplicand there.
                r_m      <= bus.op[1] ? w_abs_b : w_abs_a;
                r_acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? w_abs_a : w_abs_b)};
                r_cnt    <= CNT_INIT;
                r_is_div <= bus.op[1];
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_dbz    <= 1'b0;
              end
              OP_MTHI: r_hi <= bus.operand_a;
              OP_MTLO: r_lo <= bus.operand_a;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt - CNT_ONE;
        end
        S_FINISH: begin
          r_done <= 1'b1;
          if (r_is_div) begin
            r_hi  <= w_r_fix;
            r_lo  <= w_q_fix;
            r_dbz <= (r_m == {WIDTH{1'b0}});
          end else begin
            r_hi  <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo  <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
endmodule
